// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit scheduler and its byte queue.
package uart_tx_pkg;

  localparam int UART_FRAME_BITS = 10;

  typedef logic [7:0] byte_t;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_WAIT = 1'b1
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous DEPTH x 8 byte queue; a push is ignored while full, a pop while empty.
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  byte_t                  data_i,
  input  logic                   pop_i,
  output byte_t                  head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  byte_t           mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok;
  logic            pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array has no reset; an entry is only read after a push has written it.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (count_q <= CW'(DEPTH))
        else $error("uart_tx_fifo: occupancy %0d exceeds depth %0d", count_q, DEPTH);
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Queues store bytes headed for the UART and issues one byte per frame time,
// stalling the pipeline rather than dropping a byte when the queue is full.
module uart_tx_scheduler
  import uart_tx_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int FRAME_CYCLES = 8680
) (
  input  logic                   sysclk,
  input  logic                   cpu_reset,
  input  logic                   wr_en,
  input  byte_t                  wr_data,
  output logic                   stall_req,
  output logic                   uart_wr,
  output byte_t                  uart_dat,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   tx_idle
);

  localparam int CNT_W = $clog2(FRAME_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYCLES - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             uart_wr_q, uart_wr_d;
  byte_t            uart_dat_q, uart_dat_d;

  logic  fifo_push;
  logic  fifo_pop;
  byte_t fifo_head;
  logic  fifo_full;
  logic  fifo_empty;

  // Registered full only, so the stall never loops back through the controller.
  assign stall_req = wr_en && fifo_full;
  assign fifo_push = wr_en && !fifo_full;

  uart_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (sysclk),
    .rst_i   (cpu_reset),
    .push_i  (fifo_push),
    .data_i  (wr_data),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    uart_wr_d  = 1'b0;
    uart_dat_d = uart_dat_q;
    fifo_pop   = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          uart_wr_d  = 1'b1;
          uart_dat_d = fifo_head;
          fifo_pop   = 1'b1;
          cnt_d      = CNT_LOAD;
          state_d    = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!fifo_empty) begin
          // Back-to-back issue keeps pulses exactly one frame apart.
          uart_wr_d  = 1'b1;
          uart_dat_d = fifo_head;
          fifo_pop   = 1'b1;
          cnt_d      = CNT_LOAD;
        end else begin
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (cpu_reset) begin
      state_q    <= TX_IDLE;
      cnt_q      <= '0;
      uart_wr_q  <= 1'b0;
      uart_dat_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      uart_wr_q  <= uart_wr_d;
      uart_dat_q <= uart_dat_d;
    end
  end

  assign uart_wr  = uart_wr_q;
  assign uart_dat = uart_dat_q;
  assign tx_idle  = fifo_empty && (state_q == TX_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler at DEPTH=4, FRAME_CYCLES=8.
module tb_uart_tx_scheduler;
  import uart_tx_pkg::*;

  localparam int DEPTH = 4;
  localparam int FRAME = 8;

  logic       sysclk = 1'b0;
  logic       cpu_reset;
  logic       wr_en;
  byte_t      wr_data;
  logic       stall_req;
  logic       uart_wr;
  byte_t      uart_dat;
  logic [2:0] fifo_count;
  logic       tx_idle;

  int errors = 0;
  int checks = 0;
  int edge_no;
  int stall_seen;
  int pulse_edge [$];
  byte_t pulse_data [$];

  uart_tx_scheduler #(
    .DEPTH        (DEPTH),
    .FRAME_CYCLES (FRAME)
  ) dut (
    .sysclk     (sysclk),
    .cpu_reset  (cpu_reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .stall_req  (stall_req),
    .uart_wr    (uart_wr),
    .uart_dat   (uart_dat),
    .fifo_count (fifo_count),
    .tx_idle    (tx_idle)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  // One clock edge: sample stall before it, record any uart_wr pulse just after it.
  task automatic tick();
    #1;
    if (stall_req === 1'b1) stall_seen++;
    @(posedge sysclk);
    #1;
    if (uart_wr === 1'b1) begin
      pulse_edge.push_back(edge_no);
      pulse_data.push_back(uart_dat);
    end
    edge_no++;
  endtask

  task automatic start_scenario();
    edge_no    = 0;
    stall_seen = 0;
    pulse_edge.delete();
    pulse_data.delete();
  endtask

  task automatic check_pulse(input string tag, input int k, input int exp_edge, input byte_t exp_data);
    if (k < pulse_edge.size()) begin
      check({tag, "_edge"}, pulse_edge[k], exp_edge);
      check({tag, "_data"}, pulse_data[k], exp_data);
    end else begin
      check({tag, "_present"}, pulse_edge.size(), k + 1);
    end
  endtask

  task automatic run_until(input int last_edge);
    while (edge_no <= last_edge) tick();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (tx_idle !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check(tag, tx_idle, 1'b1);
  endtask

  task automatic single_byte(input string tag, input byte_t b);
    start_scenario();
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
    check({tag, "_count_e0"}, fifo_count, 3'd1);
    check({tag, "_wr_e0"}, uart_wr, 1'b0);
    tick();
    check({tag, "_wr_e1"}, uart_wr, 1'b1);
    check({tag, "_dat_e1"}, uart_dat, b);
    check({tag, "_count_e1"}, fifo_count, 3'd0);
    repeat (7) tick();
    check({tag, "_busy_e8"}, tx_idle, 1'b0);
    tick();
    check({tag, "_idle_e9"}, tx_idle, 1'b1);
    run_until(20);
    check({tag, "_npulses"}, pulse_edge.size(), 1);
    check_pulse({tag, "_p0"}, 0, 1, b);
  endtask

  int    idx;
  int    first_stall;
  int    cnt_at_stall;
  int    accept5;
  logic  stall_e9;
  logic  ok;
  logic [2:0] cnt_after9;
  logic [2:0] cnt_after10;

  initial begin
    cpu_reset = 1'b1;
    wr_en     = 1'b0;
    wr_data   = '0;
    start_scenario();
    tick();
    tick();
    check("rst_uart_wr", uart_wr, 1'b0);
    check("rst_uart_dat", uart_dat, 8'h00);
    check("rst_count", fifo_count, 3'd0);
    check("rst_stall", stall_req, 1'b0);
    check("rst_idle", tx_idle, 1'b1);
    cpu_reset = 1'b0;
    tick();

    // Scenario 1: single byte
    single_byte("s1", 8'h41);

    // Scenario 2: four-byte burst, one pulse per frame
    start_scenario();
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h10 + i);
      tick();
    end
    wr_en = 1'b0;
    run_until(30);
    check("s2_npulses", pulse_edge.size(), 4);
    for (int k = 0; k < 4; k++) check_pulse($sformatf("s2_p%0d", k), k, 1 + 8 * k, 8'(8'h10 + k));
    check("s2_no_stall", stall_seen, 0);
    wait_idle("s2_idle");

    // Scenarios 3 and 5: overflow with stall, rejected push on a pop edge
    start_scenario();
    idx = 0; first_stall = -1; cnt_at_stall = -1; accept5 = -1;
    stall_e9 = 1'b0; cnt_after9 = '0; cnt_after10 = '0;
    while (idx < 6 && edge_no < 40) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h20 + idx);
      #1;
      ok = (stall_req !== 1'b1);
      if (!ok && first_stall < 0) begin
        first_stall  = edge_no;
        cnt_at_stall = int'(fifo_count);
      end
      if (edge_no == 9) stall_e9 = stall_req;
      if (ok && idx == 5) accept5 = edge_no;
      tick();
      if (edge_no == 10) cnt_after9 = fifo_count;
      if (edge_no == 11) cnt_after10 = fifo_count;
      if (ok) idx++;
    end
    wr_en = 1'b0;
    check("s3_all_accepted", idx, 6);
    check("s3_first_stall_edge", first_stall, 5);
    check("s3_count_at_stall", cnt_at_stall, 4);
    check("s5_stall_on_pop_edge", stall_e9, 1'b1);
    check("s5_count_after_pop", cnt_after9, 3'd3);
    check("s5_accept_edge", accept5, 10);
    check("s5_count_after_accept", cnt_after10, 3'd4);
    run_until(50);
    check("s3_npulses", pulse_edge.size(), 6);
    for (int k = 0; k < 6; k++) check_pulse($sformatf("s3_p%0d", k), k, 1 + 8 * k, 8'(8'h20 + k));
    wait_idle("s3_idle");

    // Scenario 4: push and pop on the same edge at count 2
    start_scenario();
    wr_en = 1'b1;
    wr_data = 8'h30; tick();
    wr_data = 8'h31; tick();
    wr_data = 8'h32; tick();
    wr_en = 1'b0;
    check("s4_count_e2", fifo_count, 3'd2);
    repeat (6) tick();
    check("s4_count_e8", fifo_count, 3'd2);
    wr_en   = 1'b1;
    wr_data = 8'h33;
    tick();
    wr_en = 1'b0;
    check("s4_count_pushpop", fifo_count, 3'd2);
    check("s4_wr_e9", uart_wr, 1'b1);
    check("s4_dat_e9", uart_dat, 8'h31);
    run_until(30);
    check("s4_npulses", pulse_edge.size(), 4);
    for (int k = 0; k < 4; k++) check_pulse($sformatf("s4_p%0d", k), k, 1 + 8 * k, 8'(8'h30 + k));
    wait_idle("s4_idle");

    // Scenario 6: reset mid-WAIT with three bytes queued
    start_scenario();
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h40 + i);
      tick();
    end
    wr_en = 1'b0;
    tick();
    check("s6_count_before_rst", fifo_count, 3'd3);
    check("s6_busy_before_rst", tx_idle, 1'b0);
    cpu_reset = 1'b1;
    tick();
    check("s6_count_after_rst", fifo_count, 3'd0);
    check("s6_wr_after_rst", uart_wr, 1'b0);
    check("s6_idle_after_rst", tx_idle, 1'b1);
    check("s6_stall_after_rst", stall_req, 1'b0);
    cpu_reset = 1'b0;
    tick();
    single_byte("s6_new", 8'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
